// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the multi-channel LED fader bank.
package led_fader_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_ON      = 2'b01,
    LED_BLINK   = 2'b10,
    LED_BREATHE = 2'b11
  } led_mode_t;

  // Widest PWM resolution the triangle helper supports; callers truncate to their own width.
  localparam int TRI_W = 16;

  // Falling ramp in the lower half-period, rising ramp in the upper half.
  function automatic logic [TRI_W-1:0] tri_wave(input logic upper_half,
                                                input logic [TRI_W-1:0] msbs);
    return upper_half ? msbs : ~msbs;
  endfunction

endpackage

// File: rtl/led_pwm_sd.sv
// One LED channel: first-order sigma-delta PWM; accumulator cleared when the channel mode changes.
module led_pwm_sd #(
  parameter int MXPWMBITS = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic [MXPWMBITS:0]   duty,
  output logic                 led
);

  logic [MXPWMBITS-1:0] acc;
  logic [MXPWMBITS:0]   sum;

  assign sum = {1'b0, acc} + duty;

  // Stage boundary: carry out of the accumulator is the registered LED output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      led <= 1'b0;
    end else begin
      led <= sum[MXPWMBITS];
      acc <= clr ? '0 : sum[MXPWMBITS-1:0];
    end
  end

endmodule

// File: rtl/led_fader_bank.sv
// Multi-channel LED driver: one shared fade counter, per-channel mode/brightness, sigma-delta PWM.
module led_fader_bank
  import led_fader_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int MXFADERCNT = 27,
  parameter int MXPWMBITS  = 5,
  parameter int STAGGER    = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [2*NCH-1:0]         mode,
  input  logic [MXPWMBITS*NCH-1:0] brightness,
  output logic [NCH-1:0]           led,
  output logic                     period_sync
);

  localparam int B       = MXPWMBITS;
  localparam int BD      = MXPWMBITS + 1;
  localparam int CW      = MXFADERCNT;
  localparam int PH_STEP = (2 ** CW) / NCH;

  // An all-ones level means "fully on": promote it to 2**B so the carry never drops.
  function automatic logic [B:0] full_scale(input logic [B-1:0] lvl);
    return (&lvl) ? {1'b1, {B{1'b0}}} : {1'b0, lvl};
  endfunction

  logic [CW-1:0]    cnt;
  logic [2*NCH-1:0] mode_p0;
  logic [B*NCH-1:0] bright_p0;

  // Stage boundary p0: shared counter, wrap pulse and input capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      period_sync <= 1'b0;
      mode_p0     <= '0;
      bright_p0   <= '0;
    end else begin
      cnt         <= cnt + CW'(1);
      period_sync <= (cnt == '0);
      mode_p0     <= mode;
      bright_p0   <= brightness;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    localparam logic [CW-1:0] PH_OFS = (STAGGER != 0) ? CW'(ch * PH_STEP) : '0;

    logic          half_hi;
    logic [B-1:0]  msbs;
    logic [B-1:0]  tri_v;
    logic [B-1:0]  lvl;
    logic [B:0]    duty;
    logic          clr;
    led_mode_t     md;

    assign half_hi = 1'((cnt + PH_OFS) >> (CW - 1));
    assign msbs    = B'((cnt + PH_OFS) >> (CW - 1 - B));
    assign tri_v   = B'(tri_wave(half_hi, TRI_W'(msbs)));
    assign lvl     = bright_p0[ch*B +: B];
    assign md      = led_mode_t'(mode_p0[2*ch +: 2]);
    assign clr     = (mode[2*ch +: 2] != mode_p0[2*ch +: 2]);

    always_comb begin
      duty = '0;
      case (md)
        LED_ON:      duty = full_scale(lvl);
        LED_BLINK:   duty = half_hi ? full_scale(lvl) : '0;
        LED_BREATHE: duty = BD'(({{B{1'b0}}, tri_v} * {{B{1'b0}}, lvl}) >> B);
        default:     duty = '0;
      endcase
    end

    led_pwm_sd #(
      .MXPWMBITS(B)
    ) u_pwm (
      .clock  (clock),
      .reset_n(reset_n),
      .clr    (clr),
      .duty   (duty),
      .led    (led[ch])
    );
  end

endmodule
